// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath/memory.
// Memory handshake (valid/ready): mem_req is held high for as long as an access
// is pending; the access completes on the first rising edge where mem_req and
// mem_ready are both 1. mem_ready is ignored while mem_req is 0. Every other
// control is a per-cycle level and has no handshake.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic [3:0]       state;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_retired;

  // Sequencer side
  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, state, illegal_op, mem_timeout, instr_retired
  );

  // Datapath / memory side
  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, state, illegal_op, mem_timeout, instr_retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/mem/writeback FSM
// with memory wait states, a bounded-wait timeout, sticky fault flags and a
// retired-instruction counter. Controls are decoded from the current state.
module mips_multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_ctrl_if.master     bus
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] EXECUTE   = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] JUMP      = 4'd9;
  localparam logic [3:0] ADDI_EX   = 4'd10;
  localparam logic [3:0] ADDI_WB   = 4'd11;
  localparam logic [3:0] HALT      = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [3:0]        state_q,    state_d;
  logic [WAIT_W-1:0] wait_q,     wait_d;
  logic              illegal_q,  illegal_d;
  logic              timeout_q,  timeout_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  // Raw per-state controls, before the reset gate
  logic       c_mem_req, c_mem_we, c_i_or_d, c_ir_write, c_pc_write;
  logic       c_pc_write_cond, c_alu_src_a, c_reg_dst, c_mem_to_reg, c_reg_write;
  logic [1:0] c_pc_source, c_alu_src_b, c_alu_op;

  logic waiting;
  logic wait_expired;
  logic retire;

  // Decode datapath controls from the current state
  always_comb begin
    c_mem_req       = 1'b0;
    c_mem_we        = 1'b0;
    c_i_or_d        = 1'b0;
    c_ir_write      = 1'b0;
    c_pc_write      = 1'b0;
    c_pc_write_cond = 1'b0;
    c_pc_source     = 2'b00;
    c_alu_src_a     = 1'b0;
    c_alu_src_b     = 2'b00;
    c_alu_op        = 2'b00;
    c_reg_dst       = 1'b0;
    c_mem_to_reg    = 1'b0;
    c_reg_write     = 1'b0;
    case (state_q)
      FETCH: begin
        c_mem_req   = 1'b1;
        c_alu_src_b = 2'b01;
        // IR and PC only capture when the fetch actually completes
        c_ir_write  = bus.mem_ready;
        c_pc_write  = bus.mem_ready;
      end
      DECODE:    c_alu_src_b = 2'b11;
      MEM_ADDR: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
      end
      MEM_READ: begin
        c_mem_req = 1'b1;
        c_i_or_d  = 1'b1;
      end
      MEM_WB: begin
        c_mem_to_reg = 1'b1;
        c_reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        c_mem_req = 1'b1;
        c_mem_we  = 1'b1;
        c_i_or_d  = 1'b1;
      end
      EXECUTE: begin
        c_alu_src_a = 1'b1;
        c_alu_op    = 2'b10;
      end
      R_WB: begin
        c_reg_dst   = 1'b1;
        c_reg_write = 1'b1;
      end
      BRANCH: begin
        c_alu_src_a     = 1'b1;
        c_alu_op        = 2'b01;
        c_pc_write_cond = 1'b1;
        c_pc_source     = 2'b01;
      end
      JUMP: begin
        c_pc_write  = 1'b1;
        c_pc_source = 2'b10;
      end
      ADDI_EX: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
      end
      ADDI_WB:   c_reg_write = 1'b1;
      default: ;
    endcase
  end

  assign waiting      = c_mem_req & ~bus.mem_ready;
  assign wait_expired = waiting & (wait_q == WAIT_LAST);

  // Next state, wait counter, sticky flags and retire count
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    wait_d    = waiting ? wait_q + 1'b1 : '0;
    case (state_q)
      FETCH:     if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (bus.mem_ready) state_d = MEM_WB;
      MEM_WRITE: if (bus.mem_ready) begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      EXECUTE:   state_d = R_WB;
      ADDI_EX:   state_d = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default:   state_d = HALT;
    endcase
    // A stalled access that has used up its budget overrides everything
    if (wait_expired) begin
      state_d   = HALT;
      timeout_d = 1'b1;
      wait_d    = '0;
    end
    cnt_d = cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Controls are forced low while reset is held so an in-flight access drops at once
  assign bus.mem_req       = c_mem_req       & ~reset;
  assign bus.mem_we        = c_mem_we        & ~reset;
  assign bus.i_or_d        = c_i_or_d        & ~reset;
  assign bus.ir_write      = c_ir_write      & ~reset;
  assign bus.pc_write      = c_pc_write      & ~reset;
  assign bus.pc_write_cond = c_pc_write_cond & ~reset;
  assign bus.pc_source     = c_pc_source     & {2{~reset}};
  assign bus.alu_src_a     = c_alu_src_a     & ~reset;
  assign bus.alu_src_b     = c_alu_src_b     & {2{~reset}};
  assign bus.alu_op        = c_alu_op        & {2{~reset}};
  assign bus.reg_dst       = c_reg_dst       & ~reset;
  assign bus.mem_to_reg    = c_mem_to_reg    & ~reset;
  assign bus.reg_write     = c_reg_write     & ~reset;
  assign bus.state         = state_q;
  assign bus.illegal_op    = illegal_q;
  assign bus.mem_timeout   = timeout_q;
  assign bus.instr_retired = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS sequencer (CNT_W=4, MAX_WAIT=4).
module tb_mips_multicycle_ctrl;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk;
  logic reset;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Packed view of every control output:
  // [15]req [14]we [13]iord [12]irw [11]pcw [10]pcwc [9:8]pcsrc [7]srca [6:5]srcb [4:3]aluop [2]dst [1]m2r [0]rw
  logic [15:0] ctrl;
  assign ctrl = {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
                 bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.reg_dst, bus.mem_to_reg, bus.reg_write};

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word for a state, written out by hand from the state table
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    case (st)
      4'd0:  exp_ctrl = {1'b1, 2'b00, rdy, rdy, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000};
      4'd1:  exp_ctrl = 16'b0000_0000_0110_0000;
      4'd2:  exp_ctrl = 16'b0000_0000_1100_0000;
      4'd3:  exp_ctrl = 16'b1010_0000_0000_0000;
      4'd4:  exp_ctrl = 16'b0000_0000_0000_0011;
      4'd5:  exp_ctrl = 16'b1110_0000_0000_0000;
      4'd6:  exp_ctrl = 16'b0000_0000_1001_0000;
      4'd7:  exp_ctrl = 16'b0000_0000_0000_0101;
      4'd8:  exp_ctrl = 16'b0000_0101_1000_1000;
      4'd9:  exp_ctrl = 16'b0000_1010_0000_0000;
      4'd10: exp_ctrl = 16'b0000_0000_1100_0000;
      4'd11: exp_ctrl = 16'b0000_0000_0000_0001;
      default: exp_ctrl = 16'h0000;
    endcase
  endfunction

  // One cycle: drive mem_ready, check state and controls, advance to just past the edge
  task automatic cycle_check(input logic [3:0] st, input logic rdy);
    bus.mem_ready = rdy;
    #1;
    check("state", 32'(bus.state), 32'(st));
    check($sformatf("ctrl_s%0d", st), 32'(ctrl), 32'(exp_ctrl(st, rdy)));
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] st, input logic rdy);
    exp_q.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  task automatic run_queue();
    while (exp_q.size() > 0) cycle_check(exp_q.pop_front(), rdy_q.pop_front());
  endtask

  task automatic check_status(input string tag, input logic [3:0] st, input logic ill,
                              input logic tmo, input logic [CNT_W-1:0] cnt);
    check({tag, "_state"},   32'(bus.state),         32'(st));
    check({tag, "_illegal"}, 32'(bus.illegal_op),    32'(ill));
    check({tag, "_timeout"}, 32'(bus.mem_timeout),   32'(tmo));
    check({tag, "_retired"}, 32'(bus.instr_retired), 32'(cnt));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      #1;
      check("ctrl_in_reset", 32'(ctrl), 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    check_status("post_reset", 4'd0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = OP_LW;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // lw with no wait states: 0,1,2,3,4 then back to FETCH
    bus.opcode = OP_LW;
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1);
    run_queue();
    check_status("lw", 4'd0, 1'b0, 1'b0, 4'd1);

    // sw with three wait cycles in MEM_WRITE: 7 cycles total
    bus.opcode = OP_SW;
    push(0, 1); push(1, 1); push(2, 1);
    push(5, 0); push(5, 0); push(5, 0); push(5, 1);
    run_queue();
    check_status("sw", 4'd0, 1'b0, 1'b0, 4'd2);

    // Illegal opcode halts and stays halted
    bus.opcode = OP_BAD;
    push(0, 1); push(1, 1); push(15, 1); push(15, 1); push(15, 0);
    run_queue();
    check_status("illegal", 4'd15, 1'b1, 1'b0, 4'd2);
    do_reset(1);

    // Fetch stalls MAX_WAIT cycles -> timeout
    push(0, 0); push(0, 0); push(0, 0); push(0, 0);
    run_queue();
    check_status("timeout", 4'd15, 1'b0, 1'b1, 4'd0);
    cycle_check(15, 1);
    do_reset(1);

    // Ready on the last allowed wait cycle completes normally, then j
    bus.opcode = OP_J;
    push(0, 0); push(0, 0); push(0, 0); push(0, 1);
    push(1, 1); push(9, 1);
    run_queue();
    check_status("late_ready_j", 4'd0, 1'b0, 1'b0, 4'd1);

    // R-type, beq, addi
    bus.opcode = OP_RTYPE;
    push(0, 1); push(1, 1); push(6, 1); push(7, 1);
    run_queue();
    check("rtype_retired", 32'(bus.instr_retired), 32'd2);
    bus.opcode = OP_BEQ;
    push(0, 1); push(1, 1); push(8, 1);
    run_queue();
    check("beq_retired", 32'(bus.instr_retired), 32'd3);
    bus.opcode = OP_ADDI;
    push(0, 1); push(1, 1); push(10, 1); push(11, 1);
    run_queue();
    check("addi_retired", 32'(bus.instr_retired), 32'd4);

    // Reset mid-access in MEM_READ: request drops the same cycle
    bus.opcode = OP_LW;
    push(0, 1); push(1, 1); push(2, 1);
    run_queue();
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_reset_state", 32'(bus.state), 32'd3);
    check("mid_reset_ctrl", 32'(ctrl), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_status("mid_reset", 4'd0, 1'b0, 1'b0, 4'd0);

    // 17 back-to-back jumps: counter wraps 15 -> 0 and ends at 1
    bus.opcode = OP_J;
    for (int i = 0; i < 17; i++) begin
      push(0, 1); push(1, 1); push(9, 1);
      run_queue();
      check($sformatf("wrap_%0d", i), 32'(bus.instr_retired), 32'((i + 1) % 16));
    end
    check("wrap_final", 32'(bus.instr_retired), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
